// File: rtl/btn_pkg.sv
// Shared types and helpers for the time-multiplexed button debounce controller.
// State encodings and threshold/width derivations used by btn_scan_ctrl.
package btn_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_UPDATE = 2'd2;

  // Width needed to hold 0..cnt_max inclusive.
  function automatic int cnt_width(input int cnt_max);
    return $clog2(cnt_max + 1);
  endfunction

  // Upper threshold is 3/4 of full scale, lower is 1/4 (integer division).
  function automatic int hyst_threshold(input int cnt_max, input bit upper);
    return upper ? (3 * cnt_max) / 4 : cnt_max / 4;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Parameterised-width two-flop synchronizer for the raw button levels.
module btn_sync #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] sync
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

endmodule

// File: rtl/btn_scan_ctrl.sv
// Round-robin debounce controller: one saturating integrator shared by all buttons,
// with per-button hysteresis and single-cycle press/release events.
module btn_scan_ctrl #(
  parameter int N_BTN    = 4,
  parameter int CNT_MAX  = 1024,
  parameter int TICK_DIV = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic             o_busy,
  output logic             o_overrun
);

  import btn_pkg::*;

  localparam int CW = cnt_width(CNT_MAX);
  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int PW = $clog2(TICK_DIV);

  localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);
  localparam logic [CW-1:0] HI       = CW'(hyst_threshold(CNT_MAX, 1'b1));
  localparam logic [CW-1:0] LO       = CW'(hyst_threshold(CNT_MAX, 1'b0));
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_BTN - 1);

  logic [N_BTN-1:0] s;
  logic [PW-1:0]    pre;
  logic             tick;
  state_t           state;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    c;
  logic             b;
  logic [CW-1:0]    n;
  logic [CW-1:0]    cnt [N_BTN];

  btn_sync #(.WIDTH(N_BTN)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .raw   (i_btn),
    .sync  (s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  assign tick   = (pre == PRE_LAST);
  assign o_busy = (state != ST_IDLE);

  // Saturating step of the shared integrator; never wraps in either direction.
  always_comb begin
    n = c;
    if (b) begin
      if (c < CNT_TOP) n = c + CW'(1);
    end else if (c != '0) begin
      n = c - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      c         <= '0;
      b         <= 1'b0;
      o_btn     <= '0;
      o_press   <= '0;
      o_release <= '0;
      o_overrun <= 1'b0;
      for (int k = 0; k < N_BTN; k++) cnt[k] <= '0;
    end else begin
      o_press   <= '0;
      o_release <= '0;
      if (tick && (state != ST_IDLE)) o_overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            idx   <= '0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          c     <= cnt[idx];
          b     <= s[idx];
          state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          cnt[idx] <= n;
          // Between LO and HI the level holds, giving the hysteresis band.
          if ((n > HI) && !o_btn[idx]) begin
            o_btn[idx]   <= 1'b1;
            o_press[idx] <= 1'b1;
          end else if ((n < LO) && o_btn[idx]) begin
            o_btn[idx]     <= 1'b0;
            o_release[idx] <= 1'b1;
          end
          if (idx == IDX_LAST) begin
            state <= ST_IDLE;
          end else begin
            idx   <= idx + IW'(1);
            state <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Directed bench for btn_scan_ctrl with N_BTN=2, CNT_MAX=8 (HI=6, LO=2); a second
// instance with TICK_DIV=3 exercises tick overrun.
module tb_btn_scan_ctrl;

  import btn_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ovr_rst;
  logic [1:0] btn;
  logic [1:0] ovr_btn;

  logic [1:0] o_btn, o_press, o_release;
  logic       o_busy, o_overrun;
  logic [1:0] ovr_o_btn, ovr_o_press, ovr_o_release;
  logic       ovr_o_busy, ovr_o_overrun;

  int vectors     = 0;
  int miscompares = 0;

  int   scans_main = 0;
  int   scans_ovr  = 0;
  logic busy_q     = 1'b0;
  logic ovr_busy_q = 1'b0;
  int   press0_cnt = 0;
  int   press1_cnt = 0;
  int   rel0_cnt   = 0;
  int   rel1_cnt   = 0;
  int   multi_pulse = 0;
  logic btn1_seen  = 1'b0;

  always #5 clk = ~clk;

  btn_scan_ctrl #(.N_BTN(2), .CNT_MAX(8), .TICK_DIV(8)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_btn     (btn),
    .o_btn     (o_btn),
    .o_press   (o_press),
    .o_release (o_release),
    .o_busy    (o_busy),
    .o_overrun (o_overrun)
  );

  btn_scan_ctrl #(.N_BTN(2), .CNT_MAX(8), .TICK_DIV(3)) dut_ovr (
    .i_clk     (clk),
    .i_rst     (ovr_rst),
    .i_btn     (ovr_btn),
    .o_btn     (ovr_o_btn),
    .o_press   (ovr_o_press),
    .o_release (ovr_o_release),
    .o_busy    (ovr_o_busy),
    .o_overrun (ovr_o_overrun)
  );

  // Scan completions and event pulses, sampled mid-cycle.
  always @(negedge clk) begin
    busy_q     <= o_busy;
    ovr_busy_q <= ovr_o_busy;
    if (busy_q && !o_busy) scans_main <= scans_main + 1;
    if (ovr_busy_q && !ovr_o_busy) scans_ovr <= scans_ovr + 1;
    if (o_press[0])   press0_cnt <= press0_cnt + 1;
    if (o_press[1])   press1_cnt <= press1_cnt + 1;
    if (o_release[0]) rel0_cnt   <= rel0_cnt + 1;
    if (o_release[1]) rel1_cnt   <= rel1_cnt + 1;
    if ($countones(o_press | o_release) > 1) multi_pulse <= multi_pulse + 1;
    btn1_seen <= btn1_seen | o_btn[1];
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] val);
    btn = val;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_scans(input bit use_ovr, input int n);
    int target;
    int budget;
    target = (use_ovr ? scans_ovr : scans_main) + n;
    budget = 0;
    while (((use_ovr ? scans_ovr : scans_main) < target) && (budget < 2000)) begin
      step();
      budget++;
    end
    if ((use_ovr ? scans_ovr : scans_main) < target)
      checkOutput("scan_timeout", 32'(use_ovr ? scans_ovr : scans_main), 32'(target));
  endtask

  initial begin
    int cycles;
    int max_cnt;
    int min_cnt;
    logic btn0_rose;

    rst     = 1'b1;
    ovr_rst = 1'b1;
    btn     = 2'b00;
    ovr_btn = 2'b00;
    repeat (3) @(posedge clk);
    step();

    checkOutput("rst_btn",     32'(o_btn), 0);
    checkOutput("rst_press",   32'(o_press | o_release), 0);
    checkOutput("rst_busy",    32'(o_busy), 0);
    checkOutput("rst_overrun", 32'(o_overrun), 0);
    checkOutput("rst_cnt0",    32'(dut.cnt[0]), 0);

    rst = 1'b0;
    applyStimulus(2'b01);
    $display("[TB] press/hold on button 0");

    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!o_busy && cycles < 100);
    checkOutput("first_tick", 32'(cycles), 8);

    wait_scans(1'b0, 6);
    checkOutput("press6_cnt0", 32'(dut.cnt[0]), 6);
    checkOutput("press6_btn",  32'(o_btn), 0);
    wait_scans(1'b0, 1);
    checkOutput("press7_cnt0", 32'(dut.cnt[0]), 7);
    checkOutput("press7_btn",  32'(o_btn), 1);
    checkOutput("press7_npress", 32'(press0_cnt), 1);
    wait_scans(1'b0, 2);
    checkOutput("sat_cnt0", 32'(dut.cnt[0]), 8);

    $display("[TB] release from saturation");
    applyStimulus(2'b00);
    wait_scans(1'b0, 6);
    checkOutput("rel6_cnt0", 32'(dut.cnt[0]), 2);
    checkOutput("rel6_btn",  32'(o_btn), 1);
    wait_scans(1'b0, 1);
    checkOutput("rel7_cnt0", 32'(dut.cnt[0]), 1);
    checkOutput("rel7_btn",  32'(o_btn), 0);
    checkOutput("rel7_nrel", 32'(rel0_cnt), 1);
    wait_scans(1'b0, 1);
    checkOutput("floor_cnt0", 32'(dut.cnt[0]), 0);

    $display("[TB] bounce every tick");
    max_cnt   = 0;
    btn0_rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus((i % 2 == 0) ? 2'b01 : 2'b00);
      wait_scans(1'b0, 1);
      if (int'(dut.cnt[0]) > max_cnt) max_cnt = int'(dut.cnt[0]);
      btn0_rose = btn0_rose | o_btn[0];
    end
    checkOutput("bounce_maxcnt", 32'(max_cnt), 1);
    checkOutput("bounce_btn",    32'(btn0_rose), 0);
    checkOutput("bounce_npress", 32'(press0_cnt), 1);

    $display("[TB] hysteresis hold");
    applyStimulus(2'b01);
    wait_scans(1'b0, 7);
    checkOutput("hyst_rise_btn", 32'(o_btn), 1);
    checkOutput("hyst_npress",   32'(press0_cnt), 2);
    wait_scans(1'b0, 1);
    checkOutput("hyst_full_cnt0", 32'(dut.cnt[0]), 8);
    min_cnt = 8;
    max_cnt = 8;
    for (int r = 0; r < 4; r++) begin
      applyStimulus(2'b00);
      for (int j = 0; j < 3; j++) begin
        wait_scans(1'b0, 1);
        if (int'(dut.cnt[0]) < min_cnt) min_cnt = int'(dut.cnt[0]);
      end
      applyStimulus(2'b01);
      for (int j = 0; j < 3; j++) begin
        wait_scans(1'b0, 1);
        if (int'(dut.cnt[0]) > max_cnt) max_cnt = int'(dut.cnt[0]);
      end
    end
    checkOutput("hyst_min", 32'(min_cnt), 5);
    checkOutput("hyst_max", 32'(max_cnt), 8);
    checkOutput("hyst_btn", 32'(o_btn), 1);
    checkOutput("hyst_npress", 32'(press0_cnt), 2);
    checkOutput("hyst_nrel",   32'(rel0_cnt), 1);

    checkOutput("btn1_level",   32'(btn1_seen), 0);
    checkOutput("btn1_npress",  32'(press1_cnt), 0);
    checkOutput("btn1_nrel",    32'(rel1_cnt), 0);
    checkOutput("pulse_excl",   32'(multi_pulse), 0);

    $display("[TB] mid-scan reset");
    applyStimulus(2'b11);
    wait_scans(1'b0, 2);
    checkOutput("mid_cnt1_pre", 32'(dut.cnt[1]), 2);
    cycles = 0;
    while (!((dut.state == ST_UPDATE) && (dut.idx == 1'b1)) && cycles < 40) begin
      step();
      cycles++;
    end
    if (!((dut.state == ST_UPDATE) && (dut.idx == 1'b1)))
      checkOutput("mid_find_upd1", 32'(dut.state), 32'(ST_UPDATE));
    rst = 1'b1;
    step();
    checkOutput("mid_state",   32'(dut.state), 32'(ST_IDLE));
    checkOutput("mid_cnt1",    32'(dut.cnt[1]), 0);
    checkOutput("mid_cnt0",    32'(dut.cnt[0]), 0);
    checkOutput("mid_btn",     32'(o_btn), 0);
    checkOutput("mid_pulses",  32'(o_press | o_release), 0);
    checkOutput("mid_busy",    32'(o_busy), 0);
    rst = 1'b0;
    applyStimulus(2'b00);

    $display("[TB] overrun with TICK_DIV=3");
    step();
    ovr_btn = 2'b01;
    ovr_rst = 1'b0;
    cycles = 0;
    while (!ovr_o_busy && cycles < 100) begin
      step();
      cycles++;
    end
    checkOutput("ovr_busy_seen", 32'(ovr_o_busy), 1);
    checkOutput("ovr_before", 32'(ovr_o_overrun), 0);
    repeat (3) step();
    checkOutput("ovr_set",       32'(ovr_o_overrun), 1);
    checkOutput("ovr_scan_live", 32'(ovr_o_busy), 1);
    wait_scans(1'b1, 6);
    checkOutput("ovr6_cnt0", 32'(dut_ovr.cnt[0]), 6);
    checkOutput("ovr6_btn",  32'(ovr_o_btn), 0);
    wait_scans(1'b1, 1);
    checkOutput("ovr7_cnt0", 32'(dut_ovr.cnt[0]), 7);
    checkOutput("ovr7_btn",  32'(ovr_o_btn), 1);
    checkOutput("ovr7_cnt1", 32'(dut_ovr.cnt[1]), 0);
    checkOutput("ovr_sticky", 32'(ovr_o_overrun), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_scan_ctrl.md
# btn_scan_ctrl

Time-multiplexed debounce controller for the scope front-panel buttons. One saturating up/down integrator datapath is shared round-robin across `N_BTN` inputs. Per-button counts are held in a register array, and per-button hysteresis sets or clears a clean level. The block also emits single-cycle press and release events for the UI/menu logic. It replaces one free-running debounce counter per button, so the count datapath exists once regardless of button count.

## Interface
- `N_BTN`, default 4: number of buttons; 1..16.
- `CNT_MAX`, default 1024: integrator saturation value; 4..65535.
- `TICK_DIV`, default 64: `i_clk` cycles per scan tick; must be ≥ 2*`N_BTN`+1.
- `i_clk`, in, 1: single clock; all logic on its rising edge.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_btn`, in, `N_BTN`: raw asynchronous button levels; 1 = pressed.
- `o_btn`, out, `N_BTN`: debounced levels.
- `o_press`, out, `N_BTN`: 1-cycle pulse when `o_btn[k]` goes 0→1.
- `o_release`, out, `N_BTN`: 1-cycle pulse when `o_btn[k]` goes 1→0.
- `o_busy`, out, 1: high while a scan is in progress.
- `o_overrun`, out, 1: sticky; set when a tick arrives while busy; cleared only by reset.

## Operation
- **Input sync:** each `i_btn[k]` passes through a 2-FF synchronizer. Only the synchronized value `s[k]` is used.
- **Prescaler:** counts 0..`TICK_DIV`-1 and asserts `tick` for one cycle on wrap.
- **Constants:** `CW` = $clog2(`CNT_MAX`+1). `HI` = (3*`CNT_MAX`)/4 and `LO` = `CNT_MAX`/4, both integer division.
- **FSM states:** IDLE, LOAD, UPDATE.
  - IDLE: on `tick`, set `idx`←0 and go to LOAD.
  - LOAD: latch `c`←`cnt[idx]` and `b`←`s[idx]`; go to UPDATE.
  - UPDATE: compute `n` = `b` ? min(`c`+1, `CNT_MAX`) : max(`c`-1, 0) and write `cnt[idx]`←`n`.
    - If `n` > `HI`, the new level is 1. If `n` < `LO`, it is 0. Otherwise it holds.
    - On a level change, set or clear `o_btn[idx]` and pulse `o_press[idx]` or `o_release[idx]` in the following cycle.
    - If `idx` = `N_BTN`-1, go to IDLE; else increment `idx` and go to LOAD.
- **Thresholds:** evaluated on the updated count `n`, not the stale one.
- **Saturation:** counts never wrap.
- **Overrun:** a `tick` seen in LOAD or UPDATE is dropped; the scan continues and `o_overrun` is set.
- **Mid-scan reset:** reset asserted mid-scan aborts the scan with no partial writeback; all state returns to reset values.
- **Pulse exclusivity:** at most one bit of `o_press | o_release` is high in any cycle.

## Timing
- **Reset values:** `cnt[*]`=0, `o_btn`=0, `o_press`=0, `o_release`=0, `o_busy`=0, `o_overrun`=0, `idx`=0, sync FFs=0, prescaler=0, state=IDLE.
- **First tick:** fires `TICK_DIV` cycles after reset deassertion.
- **Scan length:** 2*`N_BTN` cycles starting the cycle after `tick`. `o_busy` is high from LOAD of idx 0 through UPDATE of idx `N_BTN`-1.
- **Pulse latency:** button k's event pulse appears 2k+3 cycles after `tick`.
- **Press latency:** for a clean press from count 0, `o_btn` rises on the (`HI`+1)-th scan tick after the synchronized level changes.
- **Release latency:** for a full release from `CNT_MAX`, `o_btn` falls when the count reaches `LO`-1, i.e. `CNT_MAX`-`LO`+1 ticks.
- **Input sampling:** each input is sampled exactly once per tick; glitches between samples are invisible.

## Structure
- **Shared package `btn_pkg`:**
  - state enum (IDLE, LOAD, UPDATE)
  - function computing `HI`/`LO` from `CNT_MAX`
  - `CW` derivation
- **Sub-module `btn_sync`:** parameterised-width 2-FF synchronizer, instantiated once with width `N_BTN`.
- **Main body:** prescaler, FSM, and count array stay in `btn_scan_ctrl`. The count array is plain registers, not inferred RAM, because reset clears it.

## Test plan
All scenarios use `N_BTN`=2, `CNT_MAX`=8, `TICK_DIV`=8, so `HI`=6 and `LO`=2.

- **Press/hold:** after reset, hold `i_btn`=01. `o_btn[0]` rises after 7 scan ticks, with exactly one `o_press[0]` pulse. `o_btn[1]`, `o_press[1]` and `o_release` stay 0 throughout.
- **Release from saturation:** with `cnt[0]`=8, drop `i_btn[0]`. `o_btn[0]` falls when the count reaches 1 (7 ticks), with one `o_release[0]` pulse.
- **Bounce:** toggle `i_btn[0]` every tick for 40 ticks. The count oscillates within 0..1 and `o_btn[0]` never rises.
- **Hysteresis hold:** after `o_btn[0]`=1, alternate 3 ticks low / 3 ticks high. The count stays within 5..8, and `o_btn[0]` stays 1 with no pulses.
- **Overrun:** with `TICK_DIV`=3 (below the 2*`N_BTN`+1 minimum), `o_overrun` sets on the first colliding tick. The scan completes, and `o_btn`/`cnt` stay consistent with one update per completed visit.
- **Mid-scan reset:** assert `i_rst` for 1 cycle during UPDATE of idx 1. The following cycle shows all outputs 0 and state IDLE, and `cnt[1]` is 0.
